apb_slave_regfile: RTL and testbench

- APB slave register file. It sits directly downstream of the APB master and consumes its psel/penable/pwrite/paddr/pwdata.
- It returns prdata/pready/pslverr to the master.
- Inserts a programmable number of wait states.
- Flags out-of-range and unaligned accesses with pslverr.
- Records master protocol violations in a sticky status bit.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_slave_regfile_if.sv | 35 +++
 rtl/apb_slv_regs.sv | 44 ++++
 rtl/apb_slave_regfile.sv | 127 ++++++++++++
 tb/tb_apb_slave_regfile.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions for the slave register file and its bus master.
//   apb_state_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   APB_DATA_W  : data bus width in bits
//   APB_STRB_W  : number of byte strobes on the data bus
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a master and apb_slave_regfile.
//   psel/penable/pwrite/paddr/pwdata : request from the master
//   pstrb                            : byte strobes (only with APB_SLV_STRB_EN)
//   prdata/pready/pslverr            : response from the slave
// Optional feature macro: APB_SLV_STRB_EN adds pstrb.
interface apb_slave_regfile_if #(
  parameter int ADDR_W = 32
);
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [APB_DATA_W-1:0] pwdata;
`ifdef APB_SLV_STRB_EN
  logic [APB_STRB_W-1:0] pstrb;
`endif
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

`ifdef APB_SLV_STRB_EN
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
`else
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
`endif

endinterface

// File: rtl/apb_slv_regs.sv
// DEPTH x 32-bit register array with byte-lane write enables.
//   clk, rst_n : clock, asynchronous active-low reset (clears every register)
//   we         : commit a write this cycle
//   wstrb      : byte lanes to update when we=1
//   idx        : register index used for both write and read
//   wdata      : write data
//   rdata      : combinational read of regs[idx]
module apb_slv_regs
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [APB_STRB_W-1:0]    wstrb,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [APB_DATA_W-1:0]    wdata,
  output logic [APB_DATA_W-1:0]    rdata
);

  logic [APB_DATA_W-1:0] regs_q [DEPTH];
  logic [APB_DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wstrb[b]) regs_d[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = regs_q[idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register file with programmable wait states, address error
// reporting and a sticky master protocol-violation flag.
//   pclk             : clock, rising edge
//   prst             : asynchronous active-low reset
//   bus              : APB slave modport (request in, prdata/pready/pslverr out)
//   protocol_err     : sticky flag, set on a master protocol violation
//   protocol_err_clr : synchronous clear of protocol_err (a same-cycle
//                      violation wins)
// Optional feature macro: APB_SLV_STRB_EN (byte strobes on writes).
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                prst,
  apb_slave_regfile_if.slave  bus,
  output logic                protocol_err,
  input  logic                protocol_err_clr
);

  localparam int IDX_W = $clog2(DEPTH);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic                  perr_q, perr_d;

  logic                  in_xfer, access, pready, err, viol, wr_en;
  logic [IDX_W-1:0]      idx;
  logic [APB_STRB_W-1:0] wstrb;
  logic [APB_DATA_W-1:0] rdata;

  assign idx = addr_q[2 +: IDX_W];
  assign err = (addr_q[1:0] != 2'b00) | (addr_q[ADDR_W-1:2+IDX_W] != '0);

  // SETUP is the state during the master's first penable cycle, so a
  // zero-wait transfer can complete there; ACCESS covers later wait cycles.
  assign in_xfer = (state_q == SETUP) | (state_q == ACCESS);
  assign access  = in_xfer & bus.psel & bus.penable;
  assign pready  = access & (cnt_q == 4'(WAIT_CYCLES));
  assign wr_en   = pready & wr_q & ~err;

`ifdef APB_SLV_STRB_EN
  assign wstrb = bus.pstrb;
`else
  assign wstrb = '1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    viol    = 1'b0;
    case (state_q)
      IDLE: begin
        // Completion returns here; the next setup cycle is recognised
        // immediately, so back-to-back transfers need no idle bus cycle.
        if (bus.psel && !bus.penable) begin
          state_d = SETUP;
          addr_d  = bus.paddr;
          wr_d    = bus.pwrite;
        end else if (bus.psel && bus.penable) begin
          viol = 1'b1;
        end
      end
      SETUP, ACCESS: begin
        if (!access) begin
          // Master failed to raise penable or abandoned the transfer.
          viol    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ACCESS;
          cnt_d   = cnt_q + 4'd1;
        end
        // Address/direction must hold while waiting; the latched copy is used.
        if (access && !pready && ((bus.paddr != addr_q) || (bus.pwrite != wr_q)))
          viol = 1'b1;
`ifdef APB_SLV_STRB_EN
        if (access && !wr_q && (bus.pstrb != '0)) viol = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    perr_d = (perr_q & ~protocol_err_clr) | viol;
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
    end
  end

  apb_slv_regs #(.DEPTH(DEPTH)) u_regs (
    .clk   (pclk),
    .rst_n (prst),
    .we    (wr_en),
    .wstrb (wstrb),
    .idx   (idx),
    .wdata (bus.pwdata),
    .rdata (rdata)
  );

  assign bus.pready    = pready;
  assign bus.pslverr   = pready & err;
  assign bus.prdata    = (pready && !wr_q && !err) ? rdata : '0;
  assign protocol_err  = perr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one zero-wait and one three-wait instance
// share a single master; a per-instance memory array predicts every result.
module tb_apb_slave_regfile;

  localparam int DEPTH = 16;
`ifdef APB_SLV_STRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        tgt = 1'b0;
  logic        m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0, m_clr = 1'b0;
  logic [31:0] m_paddr = '0, m_pwdata = '0;
`ifdef APB_SLV_STRB_EN
  logic [3:0]  m_pstrb = '0;
`endif
  logic        perr0, perr3;
  logic        s_pready, s_pslverr;
  logic [31:0] s_prdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [2][DEPTH];

  always #5 pclk = ~pclk;

  apb_slave_regfile_if #(.ADDR_W(32)) bus0 ();
  apb_slave_regfile_if #(.ADDR_W(32)) bus3 ();

  assign bus0.psel    = m_psel & ~tgt;
  assign bus3.psel    = m_psel & tgt;
  assign bus0.penable = m_penable;
  assign bus3.penable = m_penable;
  assign bus0.pwrite  = m_pwrite;
  assign bus3.pwrite  = m_pwrite;
  assign bus0.paddr   = m_paddr;
  assign bus3.paddr   = m_paddr;
  assign bus0.pwdata  = m_pwdata;
  assign bus3.pwdata  = m_pwdata;
`ifdef APB_SLV_STRB_EN
  assign bus0.pstrb   = m_pstrb;
  assign bus3.pstrb   = m_pstrb;
`endif

  assign s_pready  = tgt ? bus3.pready  : bus0.pready;
  assign s_pslverr = tgt ? bus3.pslverr : bus0.pslverr;
  assign s_prdata  = tgt ? bus3.prdata  : bus0.prdata;

  apb_slave_regfile #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .prst(prst), .bus(bus0.slave),
    .protocol_err(perr0), .protocol_err_clr(m_clr));

  apb_slave_regfile #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .prst(prst), .bus(bus3.slave),
    .protocol_err(perr3), .protocol_err_clr(m_clr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; leaves the bus deselected just after
  // the edge that ends the transfer, so a following call is back-to-back.
  task automatic xfer(input logic t, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic se, output int waits);
    bit done;
    done = 1'b0; rd = '0; se = 1'b0; waits = 0;
    tgt = t; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr;
    m_paddr = addr; m_pwdata = data;
`ifdef APB_SLV_STRB_EN
    m_pstrb = strb;
`endif
    @(posedge pclk); #1;
    m_penable = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge pclk);
      if (s_pready) begin done = 1'b1; rd = s_prdata; se = s_pslverr; end
      else waits++;
      @(posedge pclk); #1;
    end
    m_psel = 1'b0; m_penable = 1'b0;
    if (STRB_EN && strb[3]) waits = waits + 0;
    check("xfer_done", 32'(done), 32'd1);
  endtask

  // Runs one transfer and compares it against the memory model.
  task automatic op(input logic t, input logic wr, input logic [31:0] addr,
                    input logic [31:0] data, input logic [3:0] strb, input string tag);
    logic [31:0] rd, exp_rd;
    logic        se;
    int          waits, idx;
    bit          err;
    logic [3:0]  eff;
    err    = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    idx    = int'((addr / 4) % DEPTH);
    eff    = STRB_EN ? strb : 4'hF;
    exp_rd = (!wr && !err) ? mem[t][idx] : 32'h0;
    xfer(t, wr, addr, data, strb, rd, se, waits);
    check({tag, "_waits"},  32'(waits), t ? 32'd3 : 32'd0);
    check({tag, "_pslverr"}, 32'(se), 32'(err));
    check({tag, "_prdata"},  rd, exp_rd);
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (eff[b]) mem[t][idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic clear_model();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < DEPTH; i++) mem[t][i] = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, addr, data;
    logic        se;
    int          waits, cyc;
    bit          done;

    clear_model();
    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    @(negedge pclk);
    check("rst_pready0",  32'(bus0.pready), 32'd0);
    check("rst_pslverr0", 32'(bus0.pslverr), 32'd0);
    check("rst_prdata0",  bus0.prdata, 32'h0);
    check("rst_pready3",  32'(bus3.pready), 32'd0);
    check("rst_perr0",    32'(perr0), 32'd0);
    check("rst_perr3",    32'(perr3), 32'd0);
    @(posedge pclk); #1;
    prst = 1'b1;
    idle(2);

    // Zero-wait write then read
    op(1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, "w0_08");
    idle(1);
    op(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, "r0_08");
    idle(1);
    check("r0_08_model", mem[0][2], 32'hDEAD_BEEF);

    // Three wait states, read after reset
    op(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, "r3_04");
    idle(1);

    // Address errors leave every register untouched
    op(1'b0, 1'b1, 32'h40, 32'h1111_2222, 4'hF, "w0_oor");
    op(1'b0, 1'b1, 32'h02, 32'h3333_4444, 4'hF, "w0_unal");
    op(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, "r0_hi");
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b0, 32'(4 * i), 32'h0, 4'h0, "r0_scan");
    idle(1);
    check("perr0_clean", 32'(perr0), 32'd0);

    // penable without a setup cycle
    tgt = 1'b0; m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b1; m_paddr = 32'h0;
    @(negedge pclk);
    check("nosetup_pready", 32'(s_pready), 32'd0);
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge pclk);
    check("nosetup_perr", 32'(perr0), 32'd1);
    @(posedge pclk); #1;
    m_clr = 1'b1;
    @(posedge pclk); #1;
    m_clr = 1'b0;
    @(negedge pclk);
    check("clr_perr", 32'(perr0), 32'd0);
    @(posedge pclk); #1;
    check("nosetup_nowrite_model", mem[0][0], 32'h0);
    op(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, "r0_00_after_viol");

    // Clear and violation in the same cycle keep the flag set
    tgt = 1'b0; m_psel = 1'b1; m_penable = 1'b1; m_clr = 1'b1;
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0; m_clr = 1'b0;
    @(negedge pclk);
    check("clr_vs_viol", 32'(perr0), 32'd1);
    @(posedge pclk); #1;
    m_clr = 1'b1;
    @(posedge pclk); #1;
    m_clr = 1'b0;

    // paddr changed during wait states: latched address is used
    op(1'b1, 1'b1, 32'h08, 32'h5555_AAAA, 4'hF, "w3_08");
    idle(1);
    tgt = 1'b1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = 32'h04;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #1;
    m_paddr = 32'h08;
    done = 1'b0; rd = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge pclk);
      if (s_pready) begin done = 1'b1; rd = s_prdata; end
      @(posedge pclk); #1;
    end
    m_psel = 1'b0; m_penable = 1'b0;
    check("unstable_done", 32'(done), 32'd1);
    check("unstable_prdata", rd, mem[1][1]);
    check("unstable_perr", 32'(perr3), 32'd1);
    m_clr = 1'b1;
    @(posedge pclk); #1;
    m_clr = 1'b0;
    @(negedge pclk);
    check("unstable_clr", 32'(perr3), 32'd0);
    @(posedge pclk); #1;

    // Back-to-back write then read, no idle cycle between
    op(1'b0, 1'b1, 32'h0C, 32'h1234_5678, 4'hF, "b2b_w");
    op(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, "b2b_r");
    op(1'b1, 1'b1, 32'h0C, 32'h8765_4321, 4'hF, "b2b_w3");
    op(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, "b2b_r3");
    idle(1);
    check("b2b_perr0", 32'(perr0), 32'd0);
    check("b2b_perr3", 32'(perr3), 32'd0);

    // Reset in the middle of a waited write
    tgt = 1'b1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
    m_paddr = 32'h10; m_pwdata = 32'hCAFE_F00D;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    check("midrst_before", 32'(s_pready), 32'd0);
    #1 prst = 1'b0;
    #1;
    check("midrst_pready", 32'(s_pready), 32'd0);
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge pclk); #1;
    prst = 1'b1;
    clear_model();
    idle(1);
    op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "midrst_r10");
    op(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, "midrst_r08");

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      logic t, wr;
      int   kind;
      t    = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      if (kind == 0)      addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 1) addr = 32'h40 + 32'($urandom_range(0, 1000) * 4);
      else                addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      data = $urandom;
      op(t, wr, addr, data, wr ? 4'($urandom_range(0, 15)) : 4'h0, "rand");
      idle($urandom_range(0, 2));
    end
    check("rand_perr0", 32'(perr0), 32'd0);
    check("rand_perr3", 32'(perr3), 32'd0);

`ifdef APB_SLV_STRB_EN
    op(1'b0, 1'b1, 32'h00, 32'h0, 4'hF, "strb_zero");
    op(1'b0, 1'b1, 32'h00, 32'hAABB_CCDD, 4'b0101, "strb_0101");
    op(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, "strb_rd");
    check("strb_model", mem[0][0], 32'h00BB_00DD);
    op(1'b0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'b0000, "strb_none");
    op(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, "strb_none_rd");
    idle(1);
    check("strb_perr_before", 32'(perr0), 32'd0);
    xfer(1'b0, 1'b0, 32'h00, 32'h0, 4'b0010, rd, se, waits);
    check("strb_rd_data", rd, 32'h00BB_00DD);
    @(negedge pclk);
    check("strb_rd_perr", 32'(perr0), 32'd1);
    @(posedge pclk); #1;
`endif

    cyc = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
